// File: rtl/keypad_scanner.sv
// Row-scanned 4x4 active-low keypad decoder with press and release debounce.
// Emits one registered hex code and strobe per debounced press, tracking the last two digits.
module keypad_scanner #(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // The tick that bumps the counter to DEBOUNCE_TICKS-1 is the accepting tick
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 2);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    HELD,
    DEBOUNCE_RELEASE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       col_m, col_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       row_idx, row_idx_n;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_n;
  logic [3:0]       col_lat, col_lat_n;
  logic             accept;
  logic             single_press;
  logic             lat_bit_high;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [3:0] pat);
    logic [1:0] c;
    logic [3:0] code;
    case (pat)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick         = (div_cnt == DIV_LAST);
  assign single_press = ($countones(~col_s) == 1);
  assign lat_bit_high = |(~col_lat & col_s);

  // Next-state logic; every decision is taken only on a scan tick
  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    deb_cnt_n = deb_cnt;
    col_lat_n = col_lat;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_press) begin
            col_lat_n = col_s;
            deb_cnt_n = '0;
            state_n   = DEBOUNCE_PRESS;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
        DEBOUNCE_PRESS: begin
          if (col_s == col_lat) begin
            deb_cnt_n = deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n = SCAN;
          end
        end
        HELD: begin
          if (lat_bit_high) begin
            deb_cnt_n = '0;
            state_n   = DEBOUNCE_RELEASE;
          end
        end
        default: begin
          if (lat_bit_high) begin
            deb_cnt_n = deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
              state_n   = SCAN;
              row_idx_n = row_idx + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
      endcase
    end
  end

  // Synchronizer, prescaler, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      col_m     <= 4'b1111;
      col_s     <= 4'b1111;
      div_cnt   <= '0;
      state     <= SCAN;
      row_idx   <= 2'd0;
      row       <= 4'b1110;
      deb_cnt   <= '0;
      col_lat   <= 4'b1111;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      state     <= state_n;
      row_idx   <= row_idx_n;
      row       <= ~(4'b0001 << row_idx_n);
      deb_cnt   <= deb_cnt_n;
      col_lat   <= col_lat_n;
      key_valid <= accept;
      if (accept) begin
        key_code  <= key_map(row_idx, col_lat);
        digit_new <= key_map(row_idx, col_lat);
        digit_old <= digit_new;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives col from row, and a
// scoreboard queue of expected strobes is drained by an independent monitor.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;

  logic [15:0] keys = 16'h0000;
  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key at (r,c) pulls column c low while row r is driven low
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // Monitor: every strobe must match the oldest pending expectation
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset && key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe: got code=%h new=%h old=%h, expected no strobe",
                 key_code, digit_new, digit_old);
      end else begin
        e = exp_q.pop_front();
        if ({key_code, digit_new, digit_old} !== e)
          begin
            errors++;
            $display("[TB] FAIL strobe: got code/new/old=%h, expected %h",
                     {key_code, digit_new, digit_old}, e);
          end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitRow(input string name, input logic [3:0] value, input bit want_equal, input int limit);
    bit found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      if ((row == value) == want_equal) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s: row=%b, expected %s %b within %0d cycles",
               name, row, want_equal ? "==" : "!=", value, limit);
    end
  endtask

  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] K7 = 16'h0100;

  initial begin
    logic [3:0] row_seq [5];
    row_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // 1: reset state and idle row walk
    applyReset();
    checkOutput("reset_row", row, 4'b1110);
    checkOutput("reset_code", key_code, 4'h0);
    checkOutput("reset_valid", {3'b000, key_valid}, 4'h0);
    checkOutput("reset_new", digit_new, 4'h0);
    checkOutput("reset_old", digit_old, 4'h0);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      checkOutput("idle_row_seq", row, row_seq[i]);
    end

    // 2: press and hold key 5
    exp_q.push_back({4'h5, 4'h5, 4'h0});
    applyStimulus(K5, 200);
    checkOutput("held5_row", row, 4'b1101);
    checkOutput("held5_code", key_code, 4'h5);
    checkOutput("held5_new", digit_new, 4'h5);
    checkOutput("held5_old", digit_old, 4'h0);
    applyStimulus(16'h0, 100);

    // 3: one-tick bounce on key 5 is rejected and the row resumes from 1101
    waitRow("bounce_sync_leave", 4'b1101, 1'b0, 40);
    waitRow("bounce_sync_enter", 4'b1101, 1'b1, 40);
    applyStimulus(K5, 5);
    applyStimulus(16'h0, 3);
    checkOutput("bounce_row_held", row, 4'b1101);
    repeat (4) @(negedge clk);
    checkOutput("bounce_row_adv", row, 4'b1011);
    applyStimulus(16'h0, 40);

    // 4: long hold with a release glitch, clean release, then key A
    exp_q.push_back({4'h5, 4'h5, 4'h5});
    applyStimulus(K5, 400);
    applyStimulus(16'h0, 4);
    applyStimulus(K5, 100);
    checkOutput("glitch_row", row, 4'b1101);
    applyStimulus(16'h0, 100);
    exp_q.push_back({4'hA, 4'hA, 4'h5});
    applyStimulus(KA, 200);
    checkOutput("keyA_code", key_code, 4'hA);
    checkOutput("keyA_new", digit_new, 4'hA);
    checkOutput("keyA_old", digit_old, 4'h5);
    applyStimulus(16'h0, 100);

    // 5: two keys in row 2 never strobe and do not stall the scan
    keys = K7 | K9;
    waitRow("multi_reach_r2", 4'b1011, 1'b1, 40);
    waitRow("multi_pass_r2", 4'b0111, 1'b1, 8);
    applyStimulus(K7 | K9, 60);
    applyStimulus(16'h0, 20);

    // 6: reset during press debounce of key 9, then re-detection
    waitRow("rst_sync_leave", 4'b1011, 1'b0, 40);
    waitRow("rst_sync_enter", 4'b1011, 1'b1, 40);
    applyStimulus(K9, 5);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_row", row, 4'b1110);
    checkOutput("midrst_code", key_code, 4'h0);
    checkOutput("midrst_new", digit_new, 4'h0);
    checkOutput("midrst_old", digit_old, 4'h0);
    exp_q.push_back({4'h9, 4'h9, 4'h0});
    applyStimulus(K9, 200);
    checkOutput("rekey9_code", key_code, 4'h9);
    checkOutput("rekey9_row", row, 4'b1011);
    applyStimulus(16'h0, 100);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_strobes: %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad one row at a time and debounces both press and release. Each debounced press produces exactly one registered hex key code with a one-cycle valid strobe. Keeps the two most recent digits (new/old) for the time-multiplexed dual seven-segment display path. Sits between the keypad pins and the display mux in the lab 3 top level, and runs on the 48 MHz HSOSC clock.

Parameters:
SCAN_DIV, 48000, clk cycles per scan tick (1 kHz at 48 MHz); must be >= 4
DEBOUNCE_TICKS, 20, consecutive stable scan ticks needed to accept a press or a release; must be >= 2

Ports:
clk  in  1  system clock (HSOSC, 48 MHz)
reset  in  1  synchronous, active-high reset
col  in  4  keypad column inputs, active-low with external pull-ups, asynchronous
row  out  4  keypad row drives, active-low, exactly one bit low at all times
key_code  out  4  hex code of the last accepted key
key_valid  out  1  one-cycle strobe when key_code updates
digit_new  out  4  most recent accepted digit
digit_old  out  4  previously accepted digit

Behaviour:
- Reset (synchronous, active-high) sets: row=4'b1110 (row index 0), state SCAN, key_code=0, key_valid=0, digit_new=0, digit_old=0, all counters=0, col synchronizer=4'b1111.
- col passes through a 2-flop synchronizer, giving col_s. All decisions use col_s and are sampled only on a scan tick.
- Tick: prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 for the single cycle where count==SCAN_DIV-1.
- Key map (row r, col c, bit index 0 = row/col 0):
  r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
- "Single press" means col_s has exactly one bit low.
- FSM:
  SCAN: on tick, if single press, latch row index and col_s pattern, clear debounce counter, go to DEBOUNCE_PRESS (row held). Otherwise (col_s=1111 or multiple bits low) advance row index 0->1->2->3->0.
  DEBOUNCE_PRESS: on tick, if col_s equals the latched pattern, increment the counter. When the counter reaches DEBOUNCE_TICKS-1, go to HELD and accept the key. On any mismatch, return to SCAN with the same row index (no advance) and no strobe.
  HELD: row held. Other keys are ignored. On tick, if the latched column bit is high, clear the counter and go to DEBOUNCE_RELEASE.
  DEBOUNCE_RELEASE: on tick, if the latched column bit is high, increment the counter. When it reaches DEBOUNCE_TICKS-1, go to SCAN and advance the row. If the bit goes low again, return to HELD with no new strobe.
- Accepting a key (same cycle as the DEBOUNCE_PRESS->HELD transition): key_code<=map(row,col); key_valid=1 for exactly one cycle; digit_old<=digit_new; digit_new<=map(row,col).
- Latency: press stable at pins -> key_valid is 2 sync cycles plus DEBOUNCE_TICKS ticks (plus up to one tick of alignment).
- Exactly one strobe per debounced press, regardless of hold length.
- Reset mid-debounce or mid-hold aborts with no strobe. A key still held after reset is re-detected and strobes once after debounce.
- Row changes only on the cycle after a tick. SCAN_DIV >= 4 guarantees col_s has settled for the new row before the next tick.
- Outputs are registered; no combinational path from col to any output.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_TICKS=3 and a behavioural keypad model: col = pressed column low when its row is driven low.)
1. Reset, then idle col=1111 -> all outputs 0; row sequence 1110,1101,1011,0111,1110, stepping every 4 clk; key_valid never asserts.
2. Press key 5 (r1,c1) and hold -> exactly one key_valid pulse; key_code=5, digit_new=5, digit_old=0; row stays 1101 while held.
3. Press key 5 for only 1 tick, then release (bounce) -> no key_valid; FSM back in SCAN; row resumes cycling from 1101.
4. Hold 5 for 100 ticks, glitch release for 1 tick, hold again, then release cleanly, then press A (r0,c3) -> total of two strobes; final key_code=A, digit_new=A, digit_old=5.
5. Two columns low in one row (r2: c0 and c2) -> no strobe; row keeps advancing.
6. Assert reset during DEBOUNCE_PRESS of key 9 -> no strobe; outputs return to reset values; if 9 is still held after reset, exactly one strobe with key_code=9 follows.
